// File: rtl/keypad_matrix_scan.sv
// keypad_matrix_scan: ROWS x COLS keypad scanner with prescaled scan tick, N-sample press/release
// debounce and held/multi-key status. Define KEYPAD_REPEAT_EN to enable key_valid auto-repeat.
module keypad_matrix_scan #(
   parameter int TICK_DIV    = 12500,
   parameter int ROWS        = 4,
   parameter int COLS        = 3,
   parameter int DEBOUNCE    = 4,
   parameter int REPEAT_DLY  = 50,
   parameter int REPEAT_RATE = 10,
   localparam int CW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [ROWS-1:0] key_row,
   output logic [COLS-1:0] key_col,
   output logic [CW-1:0]   key_code,
   output logic            key_valid,
   output logic            key_held,
   output logic            key_multi
);
   localparam int PW  = $clog2(TICK_DIV);
   localparam int DW  = $clog2(DEBOUNCE + 1);
   localparam int CIW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int RIW = (ROWS > 1) ? $clog2(ROWS) : 1;
`ifdef KEYPAD_REPEAT_EN
   localparam int RW  = $clog2(((REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE) + 1);
`endif

   typedef enum logic [1:0] {ST_SCAN, ST_DEBNC, ST_PRESSED, ST_RELEASE} state_e;

   generate
      if (TICK_DIV < 2 || DEBOUNCE < 1 || REPEAT_DLY < 1 || REPEAT_RATE < 1) begin : g_badParams
         $error("keypad_matrix_scan: illegal parameter value");
      end
   endgenerate

   state_e          state_q;
   logic [PW-1:0]   presc_q;
   logic [DW-1:0]   cnt_q;
   logic [ROWS-1:0] pat_q;
   logic [CIW-1:0]  colIdx_q;
   logic [COLS-1:0] keyCol_q;
   logic [CW-1:0]   code_q;
   logic            valid_q;
   logic            held_q;
   logic            multi_q;
`ifdef KEYPAD_REPEAT_EN
   logic [RW-1:0]   rpt_q;
`endif

   logic            tick;
   logic [RIW-1:0]  lowRow;
   logic            multiRow;
   logic            rowsIdle;
   logic            debDone;
   logic            acceptNow;
   logic            releaseNow;
   logic [CIW-1:0]  colIdx_d;
   logic [COLS-1:0] keyCol_d;
   logic [CW-1:0]   code_d;

   assign tick = (presc_q == PW'(TICK_DIV - 1));

   // Lowest-index set row wins the key code when several rows are down together.
   always_comb begin
      lowRow = '0;
      for (int r = ROWS - 1; r >= 0; r--) begin
         if (key_row[r]) lowRow = RIW'(r);
      end
   end

   assign multiRow = ($countones(key_row) > 1);
   assign rowsIdle = (key_row == '0);
   assign debDone  = ((int'(cnt_q) + 1) >= DEBOUNCE);
   assign code_d   = CW'(int'(lowRow) * COLS + int'(colIdx_q));

   // A strobe of all zeros (just after reset) advances straight to column 0.
   assign colIdx_d = (keyCol_q == '0 || int'(colIdx_q) == COLS - 1) ? '0 : colIdx_q + 1'b1;
   assign keyCol_d = COLS'(1) << colIdx_d;

   assign acceptNow  = (state_q == ST_SCAN && keyCol_q != '0 && !rowsIdle && DEBOUNCE == 1) ||
                       (state_q == ST_DEBNC && key_row == pat_q && debDone);
   assign releaseNow = rowsIdle && ((state_q == ST_PRESSED && DEBOUNCE == 1) ||
                                    (state_q == ST_RELEASE && debDone));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_SCAN;
         presc_q  <= '0;
         cnt_q    <= '0;
         pat_q    <= '0;
         colIdx_q <= '0;
         keyCol_q <= '0;
         code_q   <= '0;
         valid_q  <= 1'b0;
         held_q   <= 1'b0;
         multi_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rpt_q    <= '0;
`endif
      end else begin
         valid_q <= 1'b0;
         presc_q <= tick ? '0 : presc_q + 1'b1;
         if (tick) begin
            if (acceptNow) begin
               state_q <= ST_PRESSED;
               code_q  <= code_d;
               multi_q <= multiRow;
               held_q  <= 1'b1;
               valid_q <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
               rpt_q   <= RW'(REPEAT_DLY);
`endif
            end else if (releaseNow) begin
               state_q  <= ST_SCAN;
               held_q   <= 1'b0;
               multi_q  <= 1'b0;
               keyCol_q <= keyCol_d;
               colIdx_q <= colIdx_d;
`ifdef KEYPAD_REPEAT_EN
               rpt_q    <= '0;
`endif
            end else begin
               case (state_q)
                  ST_SCAN: begin
                     if (keyCol_q != '0 && !rowsIdle) begin
                        pat_q   <= key_row;
                        cnt_q   <= DW'(1);
                        state_q <= ST_DEBNC;
                     end else begin
                        keyCol_q <= keyCol_d;
                        colIdx_q <= colIdx_d;
                     end
                  end
                  ST_DEBNC: begin
                     if (key_row == pat_q) begin
                        cnt_q <= cnt_q + 1'b1;
                     end else begin
                        state_q  <= ST_SCAN;
                        keyCol_q <= keyCol_d;
                        colIdx_q <= colIdx_d;
                     end
                  end
                  ST_PRESSED: begin
                     if (rowsIdle) begin
                        cnt_q   <= DW'(1);
                        state_q <= ST_RELEASE;
`ifdef KEYPAD_REPEAT_EN
                        rpt_q   <= '0;
                     end else if (rpt_q == RW'(1)) begin
                        valid_q <= 1'b1;
                        rpt_q   <= RW'(REPEAT_RATE);
                     end else if (rpt_q != '0) begin
                        rpt_q <= rpt_q - 1'b1;
`endif
                     end
                  end
                  ST_RELEASE: begin
                     if (!rowsIdle) begin
                        state_q <= ST_PRESSED;
`ifdef KEYPAD_REPEAT_EN
                        rpt_q   <= RW'(REPEAT_DLY);
`endif
                     end else begin
                        cnt_q <= cnt_q + 1'b1;
                     end
                  end
                  default: state_q <= ST_SCAN;
               endcase
            end
         end
      end
   end

   assign key_col   = keyCol_q;
   assign key_code  = code_q;
   assign key_valid = valid_q;
   assign key_held  = held_q;
   assign key_multi = multi_q;

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// tb_keypad_matrix_scan: drives a simulated key matrix into keypad_matrix_scan and scoreboards
// every key_valid against codes derived from the pressed keys (honours KEYPAD_REPEAT_EN).
module tb_keypad_matrix_scan;
   localparam int TICK_DIV    = 4;
   localparam int ROWS        = 4;
   localparam int COLS        = 3;
   localparam int DEBOUNCE    = 3;
   localparam int REPEAT_DLY  = 5;
   localparam int REPEAT_RATE = 2;
   localparam int CW          = $clog2(ROWS * COLS);

   typedef struct {
      int code;
      int multi;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [ROWS-1:0] key_row;
   logic [COLS-1:0] key_col;
   logic [CW-1:0]   key_code;
   logic            key_valid;
   logic            key_held;
   logic            key_multi;

   logic [ROWS-1:0] keyMat [COLS];
   exp_t            expQ [$];
   exp_t            monExp;
   int              total = 0;
   int              bad = 0;

   keypad_matrix_scan #(
      .TICK_DIV(TICK_DIV), .ROWS(ROWS), .COLS(COLS), .DEBOUNCE(DEBOUNCE),
      .REPEAT_DLY(REPEAT_DLY), .REPEAT_RATE(REPEAT_RATE)
   ) dut (
      .clk(clk), .rst(rst), .key_row(key_row), .key_col(key_col), .key_code(key_code),
      .key_valid(key_valid), .key_held(key_held), .key_multi(key_multi)
   );

   always #5 clk = ~clk;

   // Physical matrix: a row reads high when a pressed key sits in a strobed column.
   always_comb begin
      key_row = '0;
      for (int c = 0; c < COLS; c++) begin
         if (key_col[c]) key_row = key_row | keyMat[c];
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   function automatic int lowestRow(input logic [ROWS-1:0] mask);
      for (int r = 0; r < ROWS; r++) begin
         if (mask[r]) return r;
      end
      return 0;
   endfunction

   // Repeats that fall within hold ticks after the accept tick.
   function automatic int repeatCount(input int hold);
      int n = 0;
`ifdef KEYPAD_REPEAT_EN
      for (int k = REPEAT_DLY; k <= hold; k += REPEAT_RATE) n++;
`endif
      return n;
   endfunction

   // Scoreboard monitor: every key_valid must match the oldest expected key.
   always @(negedge clk) begin
      if (!rst && key_valid) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_valid", int'(key_code), -1);
         end else begin
            monExp = expQ.pop_front();
            checkOutput("valid_code", int'(key_code), monExp.code);
            checkOutput("valid_multi", int'(key_multi), monExp.multi);
            checkOutput("valid_held", int'(key_held), 1);
         end
      end
   end

   task automatic waitTicks(input int n);
      repeat (n * TICK_DIV) @(negedge clk);
   endtask

   task automatic waitHeld(input logic level, input string name, output int clocks);
      clocks = 0;
      while (key_held !== level && clocks < 300) begin
         @(negedge clk);
         clocks++;
      end
      if (key_held !== level) checkOutput({name, "_timeout"}, int'(key_held), int'(level));
   endtask

   task automatic waitCol(input int col);
      int n = 0;
      while (key_col == COLS'(1 << col) && n < 300) begin
         @(negedge clk);
         n++;
      end
      while (key_col != COLS'(1 << col) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (key_col != COLS'(1 << col)) checkOutput("wait_col_timeout", int'(key_col), 1 << col);
   endtask

   // Full press/hold/release of one key pattern in one column.
   task automatic applyStimulus(input logic [ROWS-1:0] mask, input int col, input int hold);
      int lat;
      exp_t e;
      e.code  = lowestRow(mask) * COLS + col;
      e.multi = ($countones(mask) > 1) ? 1 : 0;
      expQ.push_back(e);
      keyMat[col] = mask;
      waitHeld(1'b1, "press", lat);
      for (int i = 0; i < repeatCount(hold); i++) expQ.push_back(e);
      waitTicks(hold);
      keyMat[col] = '0;
      waitHeld(1'b0, "release", lat);
      checkOutput("release_latency", lat, TICK_DIV * DEBOUNCE);
      checkOutput("resume_col", int'(key_col), 1 << ((col + 1) % COLS));
      checkOutput("multi_cleared", int'(key_multi), 0);
      waitTicks(2);
   endtask

   initial begin
      int lat;
      exp_t e;
      logic [ROWS-1:0] mask;
      for (int c = 0; c < COLS; c++) keyMat[c] = '0;

      repeat (3) @(negedge clk);
      checkOutput("reset_col", int'(key_col), 0);
      checkOutput("reset_code", int'(key_code), 0);
      checkOutput("reset_valid", int'(key_valid), 0);
      checkOutput("reset_held", int'(key_held), 0);
      checkOutput("reset_multi", int'(key_multi), 0);

      rst = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         if (i == 3) checkOutput("idle_col_pre", int'(key_col), 0);
         if (i % 4 == 0) begin
            checkOutput("idle_col", int'(key_col), 1 << (((i / 4) - 1) % COLS));
            checkOutput("idle_held", int'(key_held), 0);
         end
      end

      $display("[TB] clean press row1/col1");
      applyStimulus(4'b0010, 1, 20);

      $display("[TB] bounce on row2/col0");
      waitCol(0);
      keyMat[0] = 4'b0100;
      waitTicks(2);
      keyMat[0] = '0;
      waitTicks(1);
      e.code = 2 * COLS + 0;
      e.multi = 0;
      expQ.push_back(e);
      keyMat[0] = 4'b0100;
      waitHeld(1'b1, "bounce_press", lat);
      waitTicks(2);
      keyMat[0] = '0;
      waitHeld(1'b0, "bounce_release", lat);
      waitTicks(2);

      $display("[TB] multi-key rows0+2 col2 with release dip");
      e.code = 2;
      e.multi = 1;
      expQ.push_back(e);
      keyMat[2] = 4'b0101;
      waitHeld(1'b1, "multi_press", lat);
      checkOutput("multi_flag", int'(key_multi), 1);
      waitTicks(2);
      keyMat[2] = '0;
      waitTicks(1);
      keyMat[2] = 4'b0101;
      waitTicks(2);
      checkOutput("dip_held", int'(key_held), 1);
      keyMat[2] = '0;
      waitHeld(1'b0, "multi_release", lat);
      waitTicks(2);

      $display("[TB] reset during press row3/col0");
      e.code = 3 * COLS + 0;
      e.multi = 0;
      expQ.push_back(e);
      keyMat[0] = 4'b1000;
      waitHeld(1'b1, "rst_press", lat);
      waitTicks(2);
      rst = 1'b1;
      #1;
      checkOutput("midrst_col", int'(key_col), 0);
      checkOutput("midrst_code", int'(key_code), 0);
      checkOutput("midrst_held", int'(key_held), 0);
      checkOutput("midrst_multi", int'(key_multi), 0);
      repeat (2) @(negedge clk);
      expQ.push_back(e);
      rst = 1'b0;
      waitHeld(1'b1, "rst_repress", lat);
      checkOutput("repress_latency", lat, TICK_DIV * (1 + DEBOUNCE));
      keyMat[0] = '0;
      waitHeld(1'b0, "rst_release", lat);
      waitTicks(2);

      $display("[TB] held 12 ticks row0/col2");
      applyStimulus(4'b0001, 2, 12);

      $display("[TB] random presses");
      for (int n = 0; n < 10; n++) begin
         mask = '0;
         mask[$urandom_range(0, ROWS - 1)] = 1'b1;
         if ($urandom_range(0, 3) == 0) mask[$urandom_range(0, ROWS - 1)] = 1'b1;
         applyStimulus(mask, int'($urandom_range(0, COLS - 1)), int'($urandom_range(1, 14)));
      end

      waitTicks(2);
      checkOutput("pending_expected", expQ.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/keypad_matrix_scan.md
# keypad_matrix_scan

Parametrised matrix keypad scanner that drives one-hot column strobes, samples active-high row inputs, debounces, and reports each accepted key as a linear key code with a one-cycle valid strobe. Generalises the fixed 4x3 scanner to any ROWS x COLS matrix. Adds a prescaler parameter, N-sample debounce on press and release, held/multi-key status, and optional auto-repeat. Sits between the board keypad pins and the game/entry control logic.

## Interface
- TICK_DIV, 12500: system clocks per scan tick (>= 2)
- ROWS, 4: number of row inputs
- COLS, 3: number of column strobes
- DEBOUNCE, 4: consecutive identical tick samples required to accept a press or a release (>= 1)
- REPEAT_DLY, 50: ticks from accept to first repeat (KEYPAD_REPEAT_EN only)
- REPEAT_RATE, 10: ticks between repeats (KEYPAD_REPEAT_EN only)
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- key_row  input  ROWS  row sense, active high, sampled only on tick cycles
- key_col  output  COLS  one-hot column strobe, active high
- key_code  output  CW = clog2(ROWS*COLS)  accepted key: row_index*COLS + col_index
- key_valid  output  1  one-clk pulse per accepted key (and per repeat)
- key_held  output  1  high from accept until release is accepted
- key_multi  output  1  more than one row bit set in the accepted pattern

## Operation
- Prescaler: counter 0..TICK_DIV-1; internal tick high for one clk when the counter wraps. All FSM actions occur on tick cycles only.
- SCAN:
  - On tick, if key_row != 0: capture pattern and column index, cnt=1, go to DEBOUNCE.
  - Else advance key_col one position, wrapping bit COLS-1 to bit 0.
  - First tick after reset drives bit 0.
- DEBOUNCE: key_col frozen. On tick:
  - key_row == captured: cnt++.
  - key_row != captured (including 0): return to SCAN and advance to the next column. No output change.
  - cnt reaches DEBOUNCE: go to PRESSED, latch key_code, pulse key_valid, set key_held.
  - key_code uses the lowest-index set bit of the captured pattern.
  - key_multi = (popcount > 1), latched with the code.
- PRESSED: key_col frozen. On tick, if key_row == 0: cnt=1, go to RELEASE.
- RELEASE: on tick:
  - key_row == 0: cnt++.
  - key_row != 0: back to PRESSED, no new key_valid.
  - cnt reaches DEBOUNCE: clear key_held and key_multi, return to SCAN and advance the column.
- key_code holds its value until the next accept. It is not cleared on release.
- With DEBOUNCE=1, the capture tick itself accepts.

## Timing
- Reset values:
  - key_col=0, key_code=0, key_valid=0, key_held=0, key_multi=0
  - state SCAN, prescaler 0, cnt 0
- Reset asserted mid-press forces all reset values immediately. No key_valid is emitted on deassert, even if the key is still down; the key must be re-debounced from SCAN.
- key_valid, key_code, key_held and key_multi all update on the clk edge ending the tick cycle that satisfies the accept condition. key_valid is low on the following clk.
- Worst-case press-to-valid latency: (COLS-1+DEBOUNCE) ticks, + TICK_DIV clks.
- key_row must settle within one tick after a column change; it is sampled on the tick after the strobe moves.

## Configuration
- KEYPAD_REPEAT_EN defined:
  - In PRESSED, a tick counter starts at accept.
  - key_valid re-pulses with the unchanged key_code at REPEAT_DLY ticks, then every REPEAT_RATE ticks, while the key remains held.
  - The counter is cleared on entry to RELEASE and on reset. A bounce back to PRESSED restarts the REPEAT_DLY wait.
- Not defined: exactly one key_valid per press. REPEAT_* parameters are ignored and no repeat counter logic exists.

## Test plan
All cases use TICK_DIV=4, DEBOUNCE=3, ROWS=4, COLS=3 unless noted.
- Reset release: idle rows -> key_col cycles 001,010,100,001 every 4 clks; all other outputs stay 0.
- Clean press, row1 while col bit1 is driven, held 20 ticks -> one key_valid pulse, key_code=4, key_held=1, key_multi=0. Release -> key_held=0 after 3 zero ticks, and scanning resumes at col bit2.
- Bounce: row pattern present 2 ticks, 0 for 1 tick, then steady -> no valid from the first burst; a single valid once 3 stable ticks are seen.
- Multi-key: rows 0 and 2 together on col bit2 -> key_code=2, key_multi=1. Release dip of 1 tick during hold -> no second valid.
- Reset asserted during PRESSED with the key still down -> outputs zero immediately; after deassert, valid only after a fresh scan plus 3 ticks.
- KEYPAD_REPEAT_EN, REPEAT_DLY=5, REPEAT_RATE=2, key held 12 ticks -> valid pulses at accept, +5, +7, +9, +11 ticks, all with the same code. Without the macro -> one pulse only.
